coin_accumulator: RTL
=====================

COIN_ACCUMULATOR -- requirements
Module: coin_accumulator

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, consecutive idle cycles in COLLECT before auto-commit (legal range 2..65535).
REQ-002 Parameter: MAX_CREDIT, 127, credit ceiling; must not exceed 127.
REQ-003 i_clock  input  1  clock; all state changes on its rising edge.
REQ-004 i_resetn  input  1  reset; asynchronous, active-high.
REQ-005 i_coin_valid  input  1  one-cycle strobe; a coin is present this cycle.
REQ-006 i_coin_type  input  2  coin value: 00=5, 01=10, 10=20, 11=50; sampled only when i_coin_valid=1.
REQ-007 i_commit  input  1  user "done" request; level, sampled each cycle.
REQ-008 i_cancel  input  1  user refund request; level, sampled each cycle.
REQ-009 i_ready  input  1  downstream vending stage accepts o_money this cycle.
REQ-010 o_money_valid  output  1  credit offered downstream.
REQ-011 o_money  output  7  offered credit amount.
REQ-012 o_refund_valid  output  1  one-cycle refund strobe.
REQ-013 o_refund  output  7  refund amount; qualified by o_refund_valid.
REQ-014 o_coin_reject  output  1  one-cycle pulse; coin returned, not credited.
REQ-015 o_busy  output  1  high in any state other than IDLE.

Function
REQ-016 States SHALL be IDLE, COLLECT, OFFER, REFUND; all outputs registered or decoded from registered state and credit only.
REQ-017 IDLE: credit=0; accepted coin -> credit=value, next COLLECT; i_commit/i_cancel ignored.
REQ-018 COLLECT: coin with credit+value <= MAX_CREDIT -> credit += value (8-bit intermediate sum, no wrap), idle timer cleared.
REQ-019 COLLECT: coin with credit+value > MAX_CREDIT -> o_coin_reject=1 next cycle for one cycle, credit unchanged, timer not cleared.
REQ-020 COLLECT priority: i_cancel > i_commit > timeout; i_cancel -> REFUND with coin in same cycle rejected; i_commit with coin in same cycle -> coin credited first, then OFFER.
REQ-021 Timeout: idle timer counts COLLECT cycles with no accepted coin; on TIMEOUT_CYCLES-th consecutive such cycle -> OFFER.
REQ-022 OFFER: o_money_valid=1 and o_money=credit held stable until transfer; transfer on o_money_valid & i_ready -> IDLE, credit=0.
REQ-023 OFFER: i_cancel without i_ready -> REFUND; i_cancel with i_ready same cycle -> transfer wins, no refund.
REQ-024 OFFER and REFUND: every i_coin_valid -> o_coin_reject pulse; credit unchanged.
REQ-025 REFUND: o_refund_valid=1, o_refund=credit for exactly one cycle, then IDLE with credit=0.
REQ-026 o_money SHALL be 0 whenever o_money_valid=0; o_refund SHALL be 0 whenever o_refund_valid=0.
REQ-027 Credit SHALL never exceed MAX_CREDIT; o_money is never 0 while o_money_valid=1.

Reset
REQ-028 i_resetn=1 SHALL immediately force IDLE, credit=0, timer=0, and all outputs to 0, independent of i_clock.
REQ-029 Reset mid-COLLECT/OFFER SHALL discard credit with no refund pulse; first coin after reset release is handled as in REQ-017.

Verification
REQ-030 Coins 10,20 then i_commit, i_ready=1 -> o_money_valid one cycle with o_money=30, then IDLE, o_busy=0.
REQ-031 Coins 50,50,20 (credit 120) then coin 10 -> o_coin_reject pulse, credit stays 120; i_cancel -> o_refund=120 for one cycle.
REQ-032 Coin 5 then no activity, TIMEOUT_CYCLES=4 -> o_money_valid rises after 4 idle cycles, o_money=5; hold i_ready=0 for 10 cycles -> o_money stable at 5.
REQ-033 OFFER with credit 40, i_cancel and i_ready asserted same cycle -> transfer of 40, o_refund_valid stays 0.
REQ-034 Credit 30 in COLLECT, coin 20 with i_commit same cycle -> o_money=50; coin during OFFER -> o_coin_reject, o_money stays 50.
REQ-035 Credit 70 in OFFER, assert i_resetn between clock edges -> all outputs 0 before next edge, no refund after release.

Source files
------------

// File: rtl/coin_accumulator.sv
// -----------------------------------------------------------------------------
// coin_accumulator
//
// Collects coins into a running credit and hands that credit to a downstream
// vending stage. The user can finish early (commit), ask for the money back
// (cancel), or simply walk away, in which case the credit is offered
// automatically after a run of idle cycles.
//
// Parameters
//   TIMEOUT_CYCLES  consecutive COLLECT cycles without an accepted coin before
//                   the credit is offered automatically (2..65535)
//   MAX_CREDIT      credit ceiling (at most 127)
//
// Ports
//   i_clock         clock, rising-edge active
//   i_resetn        asynchronous reset, active-high
//   i_coin_valid    one-cycle strobe, a coin is present
//   i_coin_type     coin value code: 00=5, 01=10, 10=20, 11=50
//   i_commit        user "done" request (level)
//   i_cancel        user refund request (level)
//   i_ready         downstream accepts o_money this cycle
//   o_money_valid   credit is being offered downstream
//   o_money         offered credit, 0 when not offered
//   o_refund_valid  one-cycle refund strobe
//   o_refund        refund amount, 0 when no refund
//   o_coin_reject   one-cycle pulse, coin returned uncredited
//   o_busy          high whenever the block is not IDLE
// -----------------------------------------------------------------------------
module coin_accumulator #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_CREDIT     = 127
) (
    input  logic       i_clock,
    input  logic       i_resetn,
    input  logic       i_coin_valid,
    input  logic [1:0] i_coin_type,
    input  logic       i_commit,
    input  logic       i_cancel,
    input  logic       i_ready,
    output logic       o_money_valid,
    output logic [6:0] o_money,
    output logic       o_refund_valid,
    output logic [6:0] o_refund,
    output logic       o_coin_reject,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        OFFER,
        REFUND
    } state_t;

    localparam logic [7:0]  MAX_CREDIT_W = 8'(MAX_CREDIT);
    localparam logic [15:0] TIMEOUT_W    = 16'(TIMEOUT_CYCLES);

    state_t      state;
    state_t      state_next;
    logic [6:0]  credit;
    logic [6:0]  credit_next;
    logic [15:0] timer;
    logic [15:0] timer_next;
    logic        coin_reject;
    logic        coin_reject_next;

    logic [7:0]  coin_value;
    logic [7:0]  credit_sum;
    logic        coin_fits;
    logic        coin_accepted;
    logic [15:0] timer_inc;

    // Translate the coin code into its value, kept 8 bits wide so the
    // credit-plus-coin sum below can exceed 127 without wrapping.
    always_comb begin
        coin_value = 8'd5;
        case (i_coin_type)
            2'b00:   coin_value = 8'd5;
            2'b01:   coin_value = 8'd10;
            2'b10:   coin_value = 8'd20;
            2'b11:   coin_value = 8'd50;
            default: coin_value = 8'd5;
        endcase
    end

    assign credit_sum    = {1'b0, credit} + coin_value;
    assign coin_fits     = (credit_sum <= MAX_CREDIT_W);
    assign coin_accepted = i_coin_valid && coin_fits;
    assign timer_inc     = timer + 16'd1;

    // State, credit, idle timer and the reject pulse are all registered so
    // every output is a decode of flops; reset clears them asynchronously.
    always_ff @(posedge i_clock or posedge i_resetn) begin
        if (i_resetn) begin
            state       <= IDLE;
            credit      <= 7'd0;
            timer       <= 16'd0;
            coin_reject <= 1'b0;
        end else begin
            state       <= state_next;
            credit      <= credit_next;
            timer       <= timer_next;
            coin_reject <= coin_reject_next;
        end
    end

    // Next-state logic. In COLLECT, cancel outranks commit, which outranks
    // the idle timeout. A coin arriving with commit is credited before the
    // offer; a coin arriving with cancel is returned. A rejected coin does
    // not count as activity, so it lets the idle timer keep running.
    always_comb begin
        state_next       = state;
        credit_next      = credit;
        timer_next       = timer;
        coin_reject_next = 1'b0;

        case (state)
            IDLE: begin
                credit_next = 7'd0;
                timer_next  = 16'd0;
                if (i_coin_valid) begin
                    if (coin_value <= MAX_CREDIT_W) begin
                        credit_next = coin_value[6:0];
                        state_next  = COLLECT;
                    end else begin
                        coin_reject_next = 1'b1;
                    end
                end
            end

            COLLECT: begin
                if (i_cancel) begin
                    state_next       = REFUND;
                    timer_next       = 16'd0;
                    coin_reject_next = i_coin_valid;
                end else begin
                    if (coin_accepted) begin
                        credit_next = credit_sum[6:0];
                        timer_next  = 16'd0;
                    end else begin
                        coin_reject_next = i_coin_valid;
                        timer_next       = timer_inc;
                    end

                    if (i_commit) begin
                        state_next = OFFER;
                        timer_next = 16'd0;
                    end else if (!coin_accepted && (timer_inc == TIMEOUT_W)) begin
                        state_next = OFFER;
                        timer_next = 16'd0;
                    end
                end
            end

            OFFER: begin
                coin_reject_next = i_coin_valid;
                if (i_ready) begin
                    state_next  = IDLE;
                    credit_next = 7'd0;
                end else if (i_cancel) begin
                    state_next = REFUND;
                end
            end

            REFUND: begin
                coin_reject_next = i_coin_valid;
                state_next       = IDLE;
                credit_next      = 7'd0;
            end

            default: begin
                state_next  = IDLE;
                credit_next = 7'd0;
                timer_next  = 16'd0;
            end
        endcase
    end

    // Amount outputs are forced to zero outside their qualifying state so
    // downstream never sees a stale credit value.
    assign o_money_valid  = (state == OFFER);
    assign o_money        = (state == OFFER) ? credit : 7'd0;
    assign o_refund_valid = (state == REFUND);
    assign o_refund       = (state == REFUND) ? credit : 7'd0;
    assign o_coin_reject  = coin_reject;
    assign o_busy         = (state != IDLE);

    // Simulation-only guards on the credit invariants.
    a_credit_ceiling: assert property (@(posedge i_clock) disable iff (i_resetn)
        credit <= MAX_CREDIT_W[6:0]);
    a_offer_nonzero: assert property (@(posedge i_clock) disable iff (i_resetn)
        o_money_valid |-> (o_money != 7'd0));

endmodule
